mux_scan_seq: RTL and testbench
===============================

# mux_scan_seq

Sequential select driver and sample collector sitting directly upstream of the 16:1 gate-level multiplexer. It steps the multiplexer's four select lines through channels 0..15, waits a programmable settle time on each, samples the multiplexer output, and assembles the 16 samples into a parallel word. It exposes a start/busy/done handshake for single sweeps and a continuous-scan mode.

## Interface

- SETTLE, default 1: extra cycles each select value is held before sampling; legal range 0..15; channel dwell = SETTLE+1 cycles.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request one sweep; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at the final sample edge of each sweep.
- mux_y  input  1  multiplexer output Y.
- sel  output  4  select to multiplexer; sel[0]=S0, sel[1]=S1, sel[2]=S2, sel[3]=S3.
- word  output  16  last completed sweep; word[k] = sample taken with sel=k.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when word is updated.
- changed  output  1  one-cycle pulse coincident with done when new word differs from previous word.

## Operation

- States: IDLE, DWELL, FINISH-less design: IDLE and DWELL only; done/changed are registered pulses.
- Internal: ch (4-bit channel), dcnt (4-bit dwell counter), shadow (15-bit partial word).
- IDLE: sel=0, busy=0. start=1 at an edge -> DWELL, ch=0, dcnt=0, busy=1.
- DWELL: sel=ch. Each edge with dcnt<SETTLE: dcnt+1. Edge with dcnt==SETTLE (sample edge): capture mux_y for channel ch, dcnt=0.
  - ch<15: shadow[ch]=mux_y, ch=ch+1.
  - ch==15: word={mux_y, shadow[14:0]}; done=1 next cycle; changed=1 next cycle iff new word != old word; ch wraps to 0.
    - cont=1: stay in DWELL, busy stays 1, next sweep starts at once (no gap cycle).
    - cont=0: -> IDLE, busy=0.
- start while busy: ignored (no queueing). start held high in IDLE with cont=0: new sweep begins the edge after returning to IDLE (one idle cycle between sweeps).
- word changes only at a sample edge of channel 15; holds otherwise, including through IDLE.
- shadow is not cleared between sweeps; every bit is overwritten before use.
- Reset (any time, including mid-sweep): state=IDLE, sel=0, ch=0, dcnt=0, word=16'h0000, busy=0, done=0, changed=0; partial sweep discarded.
- mux_y assumed stable at the sample edge given adequate SETTLE; no synchronizer inside.

## Timing

- Let edge t0 be the edge at which start is accepted. From t0: busy=1, sel=0.
- Channel k sampled at edge t0+(k+1)(SETTLE+1); sel becomes k+1 (or 0 after ch 15) at that same edge.
- Sweep latency: word valid and done=1 after edge t0+16(SETTLE+1); SETTLE=1 -> 32 cycles, SETTLE=0 -> 16 cycles.
- done/changed high for exactly one cycle; busy falls at the same edge done rises (cont=0).
- Continuous mode: done pulses every 16(SETTLE+1) cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- Reset: assert rst_n=0 mid-sweep (after channel 5) -> sel=0, busy=0, done=0, word=16'h0000 immediately, asynchronously; after release, stays IDLE until start.
- Single sweep, SETTLE=1, mux data 16'hA5C3 via 16:1 multiplexer instance: start pulse -> sel steps 0..15 every 2 cycles, done at t0+32, word=16'hA5C3, changed=1, busy=0.
- SETTLE=0, data 16'h0001: sweep -> done at t0+16, word=16'h0001; repeat with same data -> word=16'h0001, done=1, changed=0.
- Continuous: cont=1, data changes 16'h1234 -> 16'hFFFF between sweeps -> done every 32 cycles, words 16'h1234 then 16'hFFFF, busy never drops; clear cont -> busy falls after current sweep's done.
- start asserted during busy (channel 7) -> ignored; exactly one done; sel sequence uninterrupted.
- start held high, cont=0 -> back-to-back sweeps with one IDLE cycle between done and next sel=0 dwell.

Source files
------------

// File: rtl/mux_scan_seq.sv
// Select driver and sample collector for a 16:1 multiplexer: steps sel through
// channels 0..15, dwells SETTLE+1 cycles on each, and packs the samples into word.
module mux_scan_seq #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        mux_y,
    output logic [3:0]  sel,
    output logic [15:0] word,
    output logic        busy,
    output logic        done,
    output logic        changed
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  ch, ch_nxt;
    logic [3:0]  dcnt, dcnt_nxt;
    logic [14:0] shadow;
    logic [15:0] word_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic        changed_nxt;
    logic        sample_edge;

    // ch is held at 0 whenever the sequencer is idle, so it drives sel directly.
    assign sel = ch;

    always_comb begin
        sample_edge = (state == DWELL) && (dcnt == SETTLE_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= 4'd0;
            dcnt    <= 4'd0;
            word    <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            changed <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            dcnt    <= dcnt_nxt;
            word    <= word_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            changed <= changed_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        dcnt_nxt    = dcnt;
        word_nxt    = word;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        changed_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DWELL;
                    ch_nxt    = 4'd0;
                    dcnt_nxt  = 4'd0;
                    busy_nxt  = 1'b1;
                end
            end
            DWELL: begin
                if (!sample_edge) begin
                    dcnt_nxt = dcnt + 4'd1;
                end else begin
                    dcnt_nxt = 4'd0;
                    // Channel 15 wraps ch to 0, which also parks sel at 0 for IDLE.
                    ch_nxt   = ch + 4'd1;
                    if (ch == 4'd15) begin
                        word_nxt    = {mux_y, shadow};
                        done_nxt    = 1'b1;
                        changed_nxt = ({mux_y, shadow} != word);
                        if (!cont) begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = 4'd0;
                dcnt_nxt  = 4'd0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Partial word needs no reset: every bit is rewritten before word consumes it.
    always_ff @(posedge clk) begin
        if (sample_edge) begin
            for (int i = 0; i < 15; i++) begin
                if (ch == 4'(i)) begin
                    shadow[i] <= mux_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: two instances (SETTLE=1 and SETTLE=0) each fed by a
// behavioural 16:1 multiplexer; expected words are queued when a sweep is launched.
module tb_mux_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1, cont1, mux_y1, busy1, done1, changed1;
    logic [3:0]  sel1;
    logic [15:0] word1, data1, prev1;

    logic        start0, cont0, mux_y0, busy0, done0, changed0;
    logic [3:0]  sel0;
    logic [15:0] word0, data0, prev0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] w;
        logic        c;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    assign mux_y1 = data1[sel1];
    assign mux_y0 = data0[sel0];

    mux_scan_seq #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .mux_y(mux_y1),
        .sel(sel1), .word(word1), .busy(busy1), .done(done1), .changed(changed1)
    );

    mux_scan_seq #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .mux_y(mux_y0),
        .sel(sel0), .word(word0), .busy(busy0), .done(done0), .changed(changed0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] d);
        q1.push_back(exp_t'{w: d, c: (d != prev1)});
        prev1 = d;
    endtask

    task automatic push0(input logic [15:0] d);
        q0.push_back(exp_t'{w: d, c: (d != prev0)});
        prev0 = d;
    endtask

    task automatic wait_done1(input int limit, output int n, output exp_t e);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done1 && n < limit);
        if (q1.size() > 0) e = q1.pop_front();
        else e = {16'hxxxx, 1'bx};
    endtask

    task automatic wait_done0(input int limit, output int n, output exp_t e);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done0 && n < limit);
        if (q0.size() > 0) e = q0.pop_front();
        else e = {16'hxxxx, 1'bx};
    endtask

    task automatic test_reset;
        repeat (2) tick();
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL reset_sel got %h want 0", sel1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done1); end
        checks++; if (changed1 !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed1); end
        checks++; if (word1 !== 16'h0000) begin errors++; $display("FAIL reset_word got %h want 0000", word1); end
        checks++; if (word0 !== 16'h0000) begin errors++; $display("FAIL reset_word0 got %h want 0000", word0); end
        rst_n = 1'b1;
        repeat (4) tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy1); end
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL idle_sel got %h want 0", sel1); end
    endtask

    task automatic test_single;
        int n;
        exp_t e;
        data1 = 16'hA5C3;
        push1(data1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_t0 got %b want 1", busy1); end
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL single_sel_t0 got %h want 0", sel1); end
        n = 0;
        do begin
            tick();
            n++;
            if (!done1) begin
                checks++;
                if (sel1 !== 4'(n / 2)) begin
                    errors++; $display("FAIL single_sel cycle %0d got %h want %h", n, sel1, 4'(n / 2));
                end
            end
        end while (!done1 && n < 100);
        if (q1.size() > 0) e = q1.pop_front();
        else e = {16'hxxxx, 1'bx};
        checks++; if (n != 32) begin errors++; $display("FAIL single_latency got %0d want 32", n); end
        checks++; if (word1 !== e.w) begin errors++; $display("FAIL single_word got %h want %h", word1, e.w); end
        checks++; if (changed1 !== e.c) begin errors++; $display("FAIL single_changed got %b want %b", changed1, e.c); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy1); end
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL single_sel_end got %h want 0", sel1); end
        tick();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done1); end
        checks++; if (changed1 !== 1'b0) begin errors++; $display("FAIL single_changed_pulse got %b want 0", changed1); end
        checks++; if (word1 !== 16'hA5C3) begin errors++; $display("FAIL single_word_hold got %h want a5c3", word1); end
    endtask

    task automatic test_settle0;
        int n;
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            data0 = 16'h0001;
            push0(data0);
            start0 = 1'b1;
            tick();
            start0 = 1'b0;
            wait_done0(100, n, e);
            checks++; if (n != 16) begin errors++; $display("FAIL s0_latency run %0d got %0d want 16", r, n); end
            checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL s0_done run %0d got %b want 1", r, done0); end
            checks++; if (word0 !== e.w) begin errors++; $display("FAIL s0_word run %0d got %h want %h", r, word0, e.w); end
            checks++; if (changed0 !== e.c) begin errors++; $display("FAIL s0_changed run %0d got %b want %b", r, changed0, e.c); end
            tick();
        end
    endtask

    task automatic test_cont;
        int n;
        exp_t e;
        logic bdrop;
        data1 = 16'h1234;
        push1(data1);
        cont1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(100, n, e);
        checks++; if (n != 32) begin errors++; $display("FAIL cont_lat1 got %0d want 32", n); end
        checks++; if (word1 !== e.w) begin errors++; $display("FAIL cont_word1 got %h want %h", word1, e.w); end
        checks++; if (changed1 !== e.c) begin errors++; $display("FAIL cont_changed1 got %b want %b", changed1, e.c); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL cont_busy1 got %b want 1", busy1); end
        data1 = 16'hFFFF;
        push1(data1);
        bdrop = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (!busy1) bdrop = 1'b1;
        end while (!done1 && n < 100);
        if (q1.size() > 0) e = q1.pop_front();
        else e = {16'hxxxx, 1'bx};
        checks++; if (n != 32) begin errors++; $display("FAIL cont_lat2 got %0d want 32", n); end
        checks++; if (word1 !== e.w) begin errors++; $display("FAIL cont_word2 got %h want %h", word1, e.w); end
        checks++; if (changed1 !== e.c) begin errors++; $display("FAIL cont_changed2 got %b want %b", changed1, e.c); end
        checks++; if (bdrop !== 1'b0) begin errors++; $display("FAIL cont_busy_drop got %b want 0", bdrop); end
        push1(data1);
        cont1 = 1'b0;
        wait_done1(100, n, e);
        checks++; if (n != 32) begin errors++; $display("FAIL cont_lat3 got %0d want 32", n); end
        checks++; if (word1 !== e.w) begin errors++; $display("FAIL cont_word3 got %h want %h", word1, e.w); end
        checks++; if (changed1 !== e.c) begin errors++; $display("FAIL cont_changed3 got %b want %b", changed1, e.c); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL cont_busy_end got %b want 0", busy1); end
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL cont_idle got %b want 0", busy1); end
    endtask

    task automatic test_mid_reset;
        int n;
        int dc;
        data1 = 16'h0F0F;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (sel1 !== 4'd6 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n != 12) begin errors++; $display("FAIL mid_reach_ch6 got %0d want 12", n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL mid_sel got %h want 0", sel1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done1); end
        checks++; if (word1 !== 16'h0000) begin errors++; $display("FAIL mid_word got %h want 0000", word1); end
        prev1 = 16'h0000;
        prev0 = 16'h0000;
        #3;
        rst_n = 1'b1;
        dc = 0;
        repeat (8) begin
            tick();
            if (done1) dc++;
        end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_stay_idle got %b want 0", busy1); end
        checks++; if (dc != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", dc); end
        checks++; if (sel1 !== 4'd0) begin errors++; $display("FAIL mid_sel_idle got %h want 0", sel1); end
    endtask

    task automatic test_busy_start;
        int n;
        int dc;
        exp_t e;
        data1 = 16'h3C3C;
        push1(data1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            start1 = (n >= 14 && n < 18);
            if (!done1) begin
                checks++;
                if (sel1 !== 4'(n / 2)) begin
                    errors++; $display("FAIL busy_sel cycle %0d got %h want %h", n, sel1, 4'(n / 2));
                end
            end
        end while (!done1 && n < 100);
        start1 = 1'b0;
        if (q1.size() > 0) e = q1.pop_front();
        else e = {16'hxxxx, 1'bx};
        checks++; if (n != 32) begin errors++; $display("FAIL busy_latency got %0d want 32", n); end
        checks++; if (word1 !== e.w) begin errors++; $display("FAIL busy_word got %h want %h", word1, e.w); end
        checks++; if (changed1 !== e.c) begin errors++; $display("FAIL busy_changed got %b want %b", changed1, e.c); end
        dc = 0;
        repeat (40) begin
            tick();
            if (done1) dc++;
        end
        checks++; if (dc != 0) begin errors++; $display("FAIL busy_extra_done got %0d want 0", dc); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", busy1); end
    endtask

    task automatic test_back_to_back;
        int n;
        exp_t e;
        data0 = 16'h00F0;
        push0(data0);
        start0 = 1'b1;
        tick();
        wait_done0(100, n, e);
        checks++; if (n != 16) begin errors++; $display("FAIL b2b_lat1 got %0d want 16", n); end
        checks++; if (word0 !== e.w) begin errors++; $display("FAIL b2b_word1 got %h want %h", word0, e.w); end
        checks++; if (changed0 !== e.c) begin errors++; $display("FAIL b2b_changed1 got %b want %b", changed0, e.c); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got %b want 0", busy0); end
        data0 = 16'h0F00;
        push0(data0);
        tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", busy0); end
        checks++; if (sel0 !== 4'd0) begin errors++; $display("FAIL b2b_sel got %h want 0", sel0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL b2b_done_low got %b want 0", done0); end
        wait_done0(100, n, e);
        start0 = 1'b0;
        checks++; if (n != 16) begin errors++; $display("FAIL b2b_lat2 got %0d want 16", n); end
        checks++; if (word0 !== e.w) begin errors++; $display("FAIL b2b_word2 got %h want %h", word0, e.w); end
        checks++; if (changed0 !== e.c) begin errors++; $display("FAIL b2b_changed2 got %b want %b", changed0, e.c); end
        repeat (2) tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_stop got %b want 0", busy0); end
    endtask

    initial begin
        start1 = 1'b0; cont1 = 1'b0; data1 = 16'h0000; prev1 = 16'h0000;
        start0 = 1'b0; cont0 = 1'b0; data0 = 16'h0000; prev0 = 16'h0000;
        test_reset();
        test_single();
        test_settle0();
        test_cont();
        test_mid_reset();
        test_busy_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
